// File: rtl/tone_envelope_gen.sv
// rtl/tone_envelope_gen.sv - square-wave tone source with linear attack/release envelope
module tone_envelope_gen #(
  parameter int DIV_W    = 22,
  parameter int RAMP_DIV = 1024,
  parameter int STEP     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] note_div,
  input  logic             key_on,
  input  logic [2:0]       volume,
  output logic [15:0]      lChannel,
  output logic [15:0]      rChannel,
  output logic [1:0]       env_state,
  output logic             note_active
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ATTACK  = 2'b01,
    SUSTAIN = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [15:0] STEP16 = 16'(STEP);

  state_t           state;
  logic [14:0]      amp;
  logic             phase;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [PW-1:0]    presc;

  logic        tick;
  logic [14:0] target;
  logic [15:0] amp_w;
  logic [15:0] sum_up;
  logic [15:0] over;
  logic [14:0] amp_up;
  logic [14:0] amp_down;
  logic [14:0] amp_sus;
  logic [14:0] amp_rel;
  logic [15:0] sample;

  assign tick   = (presc == PW'(RAMP_DIV - 1));
  // ((volume+1)<<12)-1 is simply volume followed by twelve ones
  assign target = {volume, 12'hfff};
  assign amp_w  = {1'b0, amp};
  assign sum_up = amp_w + STEP16;
  assign over   = amp_w - {1'b0, target};

  assign amp_up   = (sum_up >= {1'b0, target}) ? target : sum_up[14:0];
  assign amp_down = (over > STEP16) ? 15'(amp_w - STEP16) : target;
  assign amp_sus  = (amp < target) ? amp_up : ((amp > target) ? amp_down : amp);
  assign amp_rel  = (amp_w > STEP16) ? 15'(amp_w - STEP16) : 15'd0;
  assign sample   = phase ? (16'd0 - amp_w) : amp_w;

  assign env_state   = state;
  assign note_active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      amp      <= '0;
      phase    <= 1'b0;
      cnt      <= '0;
      div_q    <= '0;
      presc    <= '0;
      lChannel <= '0;
      rChannel <= '0;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      lChannel <= sample;
      rChannel <= sample;

      // new divisor is only picked up at a half-period boundary
      if (state != IDLE && div_q != '0) begin
        if (cnt == div_q - 1'b1) begin
          cnt   <= '0;
          phase <= ~phase;
          div_q <= note_div;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          amp <= '0;
          if (key_on && note_div != '0) begin
            state <= ATTACK;
            div_q <= note_div;
            cnt   <= '0;
            phase <= 1'b0;
          end
        end
        ATTACK: begin
          if (!key_on) begin
            state <= RELEASE;
          end else begin
            if (tick) amp <= amp_up;
            if (amp >= target) state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (tick) amp <= amp_sus;
          if (!key_on) state <= RELEASE;
        end
        RELEASE: begin
          if (tick) amp <= amp_rel;
          // retrigger keeps amp, phase and counter so the restart is click-free
          if (key_on && note_div != '0) state <= ATTACK;
          else if (amp == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_envelope_gen.sv
// tb/tb_tone_envelope_gen.sv - scoreboard bench for tone_envelope_gen
module tb_tone_envelope_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] note_div = 22'd4;
  logic        key_on = 1'b1;
  logic [2:0]  volume = 3'd7;
  logic [15:0] lChannel;
  logic [15:0] rChannel;
  logic [1:0]  env_state;
  logic        note_active;

  tone_envelope_gen #(.DIV_W(22), .RAMP_DIV(4), .STEP(8192)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .note_div(note_div),
    .key_on(key_on),
    .volume(volume),
    .lChannel(lChannel),
    .rChannel(rChannel),
    .env_state(env_state),
    .note_active(note_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] l;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  bit   end_checked = 1'b0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [15:0] l, input logic [1:0] st);
    exp_t x;
    x.cyc = c;
    x.l   = l;
    x.st  = st;
    exp_q.push_back(x);
  endtask

  task automatic after_edge(input int k);
    wait (cyc >= k);
    #1;
  endtask

  // monitor: compares every output set whose cycle has a queued expectation
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_check cyc=%0d got_cyc=%0d", e.cyc, cyc);
      end else begin
        total++;
        if (lChannel !== e.l) begin
          bad++;
          $display("FAIL lChannel cyc=%0d got=%h want=%h", cyc, lChannel, e.l);
        end
        total++;
        if (rChannel !== e.l) begin
          bad++;
          $display("FAIL rChannel cyc=%0d got=%h want=%h", cyc, rChannel, e.l);
        end
        total++;
        if (env_state !== e.st) begin
          bad++;
          $display("FAIL env_state cyc=%0d got=%b want=%b", cyc, env_state, e.st);
        end
        total++;
        if (note_active !== (e.st != 2'b00)) begin
          bad++;
          $display("FAIL note_active cyc=%0d got=%b want=%b", cyc, note_active, e.st != 2'b00);
        end
      end
    end
    if (done && !end_checked) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL leftover_checks got=%0d want=0", exp_q.size());
      end
      end_checked = 1'b1;
    end
  end

  initial begin
    // reset held 3 clocks with a note requested
    push(1, 16'h0000, 2'b00);
    push(2, 16'h0000, 2'b00);
    push(3, 16'h0000, 2'b00);
    after_edge(3);
    rst_n = 1'b1;

    // attack to full scale, then sustain
    push(4,  16'h0000, 2'b01);
    push(8,  16'h2000, 2'b01);
    push(9,  16'he000, 2'b01);
    push(12, 16'hc000, 2'b01);
    push(13, 16'h4000, 2'b01);
    push(16, 16'h6000, 2'b01);
    push(17, 16'ha000, 2'b01);
    push(19, 16'ha000, 2'b01);
    push(20, 16'h8001, 2'b10);
    push(21, 16'h7fff, 2'b10);
    push(24, 16'h7fff, 2'b10);
    after_edge(24);
    key_on = 1'b0;

    // release down to zero and back to idle
    push(25, 16'h8001, 2'b11);
    push(28, 16'ha001, 2'b11);
    push(29, 16'h5fff, 2'b11);
    push(32, 16'h3fff, 2'b11);
    push(33, 16'hc001, 2'b11);
    push(36, 16'he001, 2'b11);
    push(37, 16'h1fff, 2'b11);
    push(39, 16'h1fff, 2'b11);
    push(40, 16'h0000, 2'b00);
    push(41, 16'h0000, 2'b00);
    push(44, 16'h0000, 2'b00);
    after_edge(44);
    key_on = 1'b1;

    // new note, release, retrigger mid-half-period at amp 16383
    after_edge(60);
    key_on = 1'b0;
    push(61, 16'h8001, 2'b11);
    push(64, 16'h5fff, 2'b11);
    push(68, 16'hc001, 2'b11);
    push(69, 16'hc001, 2'b11);
    push(70, 16'h3fff, 2'b01);
    push(72, 16'h5fff, 2'b01);
    push(73, 16'h5fff, 2'b01);
    push(74, 16'ha001, 2'b01);
    push(76, 16'h8001, 2'b10);
    push(77, 16'h8001, 2'b10);
    push(78, 16'h7fff, 2'b10);
    after_edge(69);
    key_on = 1'b1;

    // divisor 4 -> 8 while cnt=1
    after_edge(78);
    note_div = 22'd8;
    push(81, 16'h7fff, 2'b10);
    push(82, 16'h8001, 2'b10);
    push(89, 16'h8001, 2'b10);
    push(90, 16'h7fff, 2'b10);
    push(97, 16'h7fff, 2'b10);
    push(98, 16'h8001, 2'b10);

    // volume drop in sustain: glide to 4095 and hold
    after_edge(98);
    volume = 3'd0;
    push(100, 16'ha001, 2'b10);
    push(104, 16'hc001, 2'b10);
    push(108, 16'h1fff, 2'b10);
    push(112, 16'h0fff, 2'b10);
    push(114, 16'hf001, 2'b10);
    push(120, 16'hf001, 2'b10);

    // release from 4095 clamps to zero in one tick
    after_edge(120);
    key_on = 1'b0;
    push(121, 16'hf001, 2'b11);
    push(124, 16'h0000, 2'b00);

    // key held with no note stays idle
    after_edge(124);
    note_div = 22'd0;
    key_on = 1'b1;
    push(128, 16'h0000, 2'b00);
    push(132, 16'h0000, 2'b00);

    // reset overrides an active note
    after_edge(132);
    note_div = 22'd4;
    push(133, 16'h0000, 2'b01);
    after_edge(133);
    rst_n = 1'b0;
    push(134, 16'h0000, 2'b00);
    push(135, 16'h0000, 2'b00);

    after_edge(137);
    done = 1'b1;
    wait (end_checked);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
